// File: rtl/uba_pkg.sv
// Shared KS10 IO-bus definitions: address-word flag positions, bridge/address
// field slices and the device front-end FSM state type.
package uba_pkg;

    localparam int unsigned FLAG_READ  = 3;
    localparam int unsigned FLAG_WRITE = 5;
    localparam int unsigned FLAG_WRU   = 6;
    localparam int unsigned FLAG_BYTE  = 12;
    localparam int unsigned FLAG_IO    = 13;

    localparam int unsigned BRIDGE_MSB = 15;
    localparam int unsigned BRIDGE_LSB = 17;
    localparam int unsigned ADDR_MSB   = 18;
    localparam int unsigned ADDR_LSB   = 35;

    localparam int unsigned BUS_W    = 36;
    localparam int unsigned HALF_W   = 18;
    localparam int unsigned BRIDGE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        ACK
    } devif_state_t;

    // Bus words are numbered PDP-10 style, bit 0 is the MSB.
    function automatic logic [BRIDGE_W-1:0] bridgeOf(input logic [0:BUS_W-1] addrWord);
        return addrWord[BRIDGE_MSB:BRIDGE_LSB];
    endfunction

    function automatic logic [HALF_W-1:0] ioAddrOf(input logic [0:BUS_W-1] addrWord);
        return addrWord[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/uba_devif_dec.sv
// Combinational request decode: bridge match, register window hit, register
// index and the transfer-type flags of the current address word.
module uba_devif_dec
    import uba_pkg::*;
#(
    parameter logic [2:0]  UBANUM   = 3'd3,
    parameter logic [17:0] BASEADDR = 18'o760010,
    parameter int unsigned NREGS    = 8,
    localparam int unsigned IDXW    = $clog2(NREGS)
) (
    input  logic              devREQI,
    input  logic [0:35]       devADDRI,
    output logic              sel,
    output logic              wru,
    output logic              isRead,
    output logic              isWrite,
    output logic              isByte,
    output logic              isHi,
    output logic [IDXW-1:0]   regIdx
);

    localparam int unsigned SPAN = 2 * NREGS;

    logic [HALF_W-1:0] addr;
    logic [HALF_W-1:0] offset;
    logic              bridgeHit;
    logic              inRange;
    logic              unusedBits;

    assign addr      = ioAddrOf(devADDRI);
    assign offset    = addr - BASEADDR;
    assign bridgeHit = (bridgeOf(devADDRI) == UBANUM);
    // The subtraction wraps below BASEADDR, so the lower bound is checked separately.
    assign inRange   = (addr >= BASEADDR) && (offset < HALF_W'(SPAN));

    assign sel     = devREQI & devADDRI[FLAG_IO] & bridgeHit & inRange;
    assign wru     = devREQI & devADDRI[FLAG_WRU] & bridgeHit;
    assign isRead  = devADDRI[FLAG_READ];
    assign isWrite = devADDRI[FLAG_WRITE];
    assign isByte  = devADDRI[FLAG_BYTE];
    assign isHi    = addr[0];
    assign regIdx  = offset[IDXW:1];

    assign unusedBits = ^{devADDRI[0:2], devADDRI[4], devADDRI[7:11], devADDRI[14],
                          offset[HALF_W-1:IDXW+1], offset[0]};

endmodule

// File: rtl/uba_devif.sv
// Generic UBA device front end: turns IO-bus requests into register strobes
// with a wait-state read return. Define UBA_DEVIF_INTR_EN for interrupt/WRU support.
module uba_devif
    import uba_pkg::*;
#(
    parameter logic [2:0]  UBANUM   = 3'd3,
    parameter logic [17:0] BASEADDR = 18'o760010,
    parameter int unsigned NREGS    = 8,
    parameter logic [17:0] VECT     = 18'o000300,
    parameter logic [3:0]  INTLEV   = 4'b0100,
    localparam int unsigned IDXW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              devRESET,
    input  logic              devREQI,
    input  logic [0:35]       devADDRI,
    input  logic [0:35]       devDATAI,
    input  logic              devACKI,
    output logic              devACKO,
    output logic [0:35]       devDATAO,
    output logic [7:4]        devINTRO,
    output logic              devREQO,
    output logic [0:35]       devADDRO,
    output logic              devACLO,
    output logic [IDXW-1:0]   regADDR,
    output logic              regWR,
    output logic              regRD,
    output logic              regBYTE,
    output logic              regHI,
    output logic [17:0]       regWDATA,
    input  logic [17:0]       regRDATA,
    input  logic              regRDY,
    input  logic              intREQ,
    output logic              intACK
);

    devif_state_t      state;
    logic              sel;
    logic              wru;
    logic              isRead;
    logic              isWrite;
    logic              isByte;
    logic              isHi;
    logic [IDXW-1:0]   regIdx;
    logic              unusedIn;

    uba_devif_dec #(
        .UBANUM   (UBANUM),
        .BASEADDR (BASEADDR),
        .NREGS    (NREGS)
    ) u_dec (
        .devREQI  (devREQI),
        .devADDRI (devADDRI),
        .sel      (sel),
        .wru      (wru),
        .isRead   (isRead),
        .isWrite  (isWrite),
        .isByte   (isByte),
        .isHi     (isHi),
        .regIdx   (regIdx)
    );

    // DMA mastering is not supported; the master side of the bus stays quiet.
    assign devREQO  = 1'b0;
    assign devADDRO = '0;
    assign devACLO  = 1'b0;

    // Request FSM; write wins when both read and write flags are set.
    always_ff @(posedge clk) begin
        if (rst || devRESET) begin
            state    <= IDLE;
            regWR    <= 1'b0;
            regRD    <= 1'b0;
            devACKO  <= 1'b0;
            devDATAO <= '0;
            regADDR  <= '0;
            regBYTE  <= 1'b0;
            regHI    <= 1'b0;
            regWDATA <= '0;
`ifdef UBA_DEVIF_INTR_EN
            intACK   <= 1'b0;
`endif
        end else begin
            regWR   <= 1'b0;
            regRD   <= 1'b0;
            devACKO <= 1'b0;
`ifdef UBA_DEVIF_INTR_EN
            intACK  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel && isWrite) begin
                        regADDR  <= regIdx;
                        regBYTE  <= isByte;
                        regHI    <= isHi;
                        regWDATA <= devDATAI[18:35];
                        regWR    <= 1'b1;
                        devACKO  <= 1'b1;
                        state    <= WRITE;
                    end else if (sel && isRead) begin
                        regADDR  <= regIdx;
                        regBYTE  <= isByte;
                        regHI    <= isHi;
                        regRD    <= 1'b1;
                        state    <= READ;
`ifdef UBA_DEVIF_INTR_EN
                    end else if (wru && (devINTRO != 4'b0000)) begin
                        devDATAO <= {18'b0, VECT};
                        devACKO  <= 1'b1;
                        intACK   <= 1'b1;
                        state    <= ACK;
`endif
                    end
                end
                WRITE: state <= IDLE;
                READ, RDWAIT: begin
                    // No timeout: a device that never raises regRDY stalls here until reset.
                    if (regRDY) begin
                        devDATAO <= {18'b0, regRDATA};
                        devACKO  <= 1'b1;
                        state    <= ACK;
                    end else begin
                        state    <= RDWAIT;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UBA_DEVIF_INTR_EN
    // Interrupt level follows intREQ one cycle later.
    always_ff @(posedge clk) begin
        if (rst || devRESET) begin
            devINTRO <= '0;
        end else begin
            devINTRO <= intREQ ? INTLEV : 4'b0000;
        end
    end

    assign unusedIn = ^{devACKI, devDATAI[0:17]};
`else
    assign devINTRO = '0;
    assign intACK   = 1'b0;
    assign unusedIn = ^{devACKI, devDATAI[0:17], intREQ, wru, VECT, INTLEV};
`endif

endmodule

// File: tb/tb_uba_devif.sv
// Self-checking bench for uba_devif: directed cases plus randomized traffic
// against a transaction-schedule model of expected per-cycle outputs.
module tb_uba_devif;

`ifdef UBA_DEVIF_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif
    localparam int unsigned BASE   = 18'o760010;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned VECTV  = 18'o000300;
    localparam logic [3:0]  INTLEV = 4'b0100;
    localparam int          NC     = 8192;
    localparam int          NRAND  = 3000;

    logic        clk = 1'b0;
    logic        rst, devRESET, devREQI, devACKI;
    logic [0:35] devADDRI, devDATAI;
    logic        devACKO, devREQO, devACLO;
    logic [0:35] devDATAO, devADDRO;
    logic [3:0]  devINTRO;
    logic [2:0]  regADDR;
    logic        regWR, regRD, regBYTE, regHI;
    logic [17:0] regWDATA, regRDATA;
    logic        regRDY, intREQ, intACK;

    uba_devif dut (
        .clk(clk), .rst(rst), .devRESET(devRESET),
        .devREQI(devREQI), .devADDRI(devADDRI), .devDATAI(devDATAI), .devACKI(devACKI),
        .devACKO(devACKO), .devDATAO(devDATAO), .devINTRO(devINTRO),
        .devREQO(devREQO), .devADDRO(devADDRO), .devACLO(devACLO),
        .regADDR(regADDR), .regWR(regWR), .regRD(regRD), .regBYTE(regBYTE), .regHI(regHI),
        .regWDATA(regWDATA), .regRDATA(regRDATA), .regRDY(regRDY),
        .intREQ(intREQ), .intACK(intACK)
    );

    always #5 clk = ~clk;

    int  nCmp = 0;
    int  nBad = 0;
    int  cyc  = 0;
    bit  checking = 1'b0;

    // Expected outputs per cycle, filled in ahead of time by the model.
    bit          expWr[NC], expRd[NC], expAck[NC], expIAck[NC], dChg[NC];
    logic [2:0]  expAddr[NC];
    bit          expByte[NC], expHi[NC];
    logic [17:0] expWd[NC];
    logic [35:0] dVal[NC];
    logic [3:0]  expIntro[NC];
    int          freeAt  = 0;
    bit          waiting = 1'b0;
    logic [35:0] runData = '0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s cyc=%0d got=%0o want=%0o", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [0:35] mkAddr(input bit rd, input bit wr, input bit wru, input bit byt,
                                           input bit io, input logic [2:0] br, input logic [17:0] a);
        logic [0:35] w;
        w = '0;
        w[3] = rd; w[5] = wr; w[6] = wru; w[12] = byt; w[13] = io;
        w[15:17] = br;
        w[18:35] = a;
        return w;
    endfunction

    // Consume this cycle's inputs and schedule what the outputs must be next cycle.
    task automatic runModel();
        int          t;
        int unsigned a;
        logic [0:35] w;
        bit          hit;
        t = cyc;
        w = devADDRI;
        if (rst || devRESET) begin
            waiting       = 1'b0;
            freeAt        = t + 1;
            dChg[t+1]     = 1'b1;
            dVal[t+1]     = '0;
            expIntro[t+1] = 4'b0000;
            return;
        end
        expIntro[t+1] = (INTR && intREQ) ? INTLEV : 4'b0000;
        if (waiting) begin
            if (regRDY) begin
                expAck[t+1] = 1'b1;
                dChg[t+1]   = 1'b1;
                dVal[t+1]   = {18'b0, regRDATA};
                freeAt      = t + 2;
                waiting     = 1'b0;
            end
        end else if (t >= freeAt && devREQI) begin
            a   = int'(w[18:35]);
            hit = w[13] && (w[15:17] == 3'd3) && (a >= BASE) && (a < BASE + 2 * NREGS);
            if (hit && (w[5] || w[3])) begin
                expAddr[t+1] = 3'((a - BASE) / 2);
                expByte[t+1] = w[12];
                expHi[t+1]   = a[0];
                if (w[5]) begin
                    expWr[t+1]  = 1'b1;
                    expAck[t+1] = 1'b1;
                    expWd[t+1]  = devDATAI[18:35];
                    freeAt      = t + 2;
                end else begin
                    expRd[t+1] = 1'b1;
                    waiting    = 1'b1;
                    freeAt     = NC * 4;
                end
            end else if (INTR && w[6] && (w[15:17] == 3'd3) && (expIntro[t] != 4'b0000)) begin
                expAck[t+1]  = 1'b1;
                expIAck[t+1] = 1'b1;
                dChg[t+1]    = 1'b1;
                dVal[t+1]    = 36'(VECTV);
                freeAt       = t + 2;
            end
        end
    endtask

    task automatic step();
        runModel();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 1) checking = 1'b1;
        if (cyc >= NC - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 2);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic idle();
        rst = 1'b0; devRESET = 1'b0; devREQI = 1'b0; devADDRI = '0; devDATAI = '0;
        regRDY = 1'b0; regRDATA = '0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int t;
        if (checking) begin
            t = cyc;
            if (dChg[t]) runData = dVal[t];
            chk("regWR",    36'(regWR),    36'(expWr[t]));
            chk("regRD",    36'(regRD),    36'(expRd[t]));
            chk("devACKO",  36'(devACKO),  36'(expAck[t]));
            chk("intACK",   36'(intACK),   36'(expIAck[t]));
            chk("devINTRO", 36'(devINTRO), 36'(expIntro[t]));
            chk("devDATAO", devDATAO,      runData);
            chk("tied0",    {devREQO, devACLO, devADDRO[2:35]}, 36'd0);
            if (expWr[t] || expRd[t]) begin
                chk("regADDR", 36'(regADDR), 36'(expAddr[t]));
                chk("regBYTE", 36'(regBYTE), 36'(expByte[t]));
                chk("regHI",   36'(regHI),   36'(expHi[t]));
            end
            if (expWr[t]) chk("regWDATA", 36'(regWDATA), 36'(expWd[t]));
        end
    end

    logic [17:0] rdv;

    initial begin
        idle();
        devACKI = 1'b0;
        intREQ  = 1'b0;
        rst     = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_ack",  36'(devACKO),  36'd0);
        chk("rst_data", devDATAO,      36'd0);
        chk("rst_strb", 36'({regWR, regRD, intACK}), 36'd0);
        chk("rst_misc", 36'({regADDR, regBYTE, regHI, devINTRO}), 36'd0);
        chk("rst_wd",   36'(regWDATA), 36'd0);

        // Write 123456 to register 1.
        devREQI = 1'b1; devADDRI = mkAddr(0, 1, 0, 0, 1, 3'd3, 18'o760012);
        devDATAI = 36'o000000123456;
        step();
        idle();
        chk("wr_regWR", 36'(regWR),    36'd1);
        chk("wr_ack",   36'(devACKO),  36'd1);
        chk("wr_addr",  36'(regADDR),  36'd1);
        chk("wr_data",  36'(regWDATA), 36'o123456);
        step();

        // Read register 3 with data ready immediately.
        regRDY = 1'b1; regRDATA = 18'o054321;
        devREQI = 1'b1; devADDRI = mkAddr(1, 0, 0, 0, 1, 3'd3, 18'o760016);
        step();
        devREQI = 1'b0; devADDRI = '0;
        chk("rd_regRD", 36'(regRD),   36'd1);
        chk("rd_ack1",  36'(devACKO), 36'd0);
        step();
        chk("rd_ack2",  36'(devACKO), 36'd1);
        chk("rd_data",  devDATAO,     36'o000000054321);
        idle();
        step();

        // Read with delayed ready and a stray request during the wait.
        devREQI = 1'b1; devADDRI = mkAddr(1, 0, 0, 0, 1, 3'd3, 18'o760010);
        step();
        devREQI = 1'b1; devADDRI = mkAddr(0, 1, 0, 0, 1, 3'd3, 18'o760012);
        step();
        idle();
        chk("wait_noWR", 36'(regWR), 36'd0);
        chk("wait_noRD", 36'(regRD), 36'd0);
        step(); step(); step();
        regRDY = 1'b1; regRDATA = 18'o000777;
        chk("wait_ack0", 36'(devACKO), 36'd0);
        step();
        idle();
        chk("wait_ack1", 36'(devACKO), 36'd1);
        chk("wait_data", devDATAO,     36'o000000000777);
        step();

        // Out of range and wrong bridge: never acknowledged.
        devREQI = 1'b1; devADDRI = mkAddr(1, 0, 0, 0, 1, 3'd3, 18'o760030);
        step();
        devREQI = 1'b1; devADDRI = mkAddr(0, 1, 0, 0, 1, 3'd1, 18'o760012);
        step();
        chk("oor_ack", 36'({devACKO, regRD, regWR}), 36'd0);
        idle();
        step();
        chk("brg_ack", 36'({devACKO, regRD, regWR}), 36'd0);
        step();

        // devRESET while waiting on regRDY drops the read.
        devREQI = 1'b1; devADDRI = mkAddr(1, 0, 0, 0, 1, 3'd3, 18'o760014);
        step();
        idle();
        step();
        devRESET = 1'b1;
        step();
        devRESET = 1'b0; regRDY = 1'b1; regRDATA = 18'o111111;
        chk("drst_data", devDATAO, 36'd0);
        step();
        chk("drst_ack1", 36'(devACKO), 36'd0);
        step();
        chk("drst_ack2", 36'(devACKO), 36'd0);
        idle();
        devREQI = 1'b1; devADDRI = mkAddr(0, 1, 0, 1, 1, 3'd3, 18'o760021);
        devDATAI = 36'o000000000042;
        step();
        idle();
        chk("drst_wr",  36'({regWR, devACKO}), 36'b11);
        chk("drst_adr", 36'({regADDR, regBYTE, regHI}), 36'b100_1_1);
        step();

        // Interrupt request and WRU vector read.
        intREQ = 1'b1;
        step();
        chk("int_lev", 36'(devINTRO), INTR ? 36'(INTLEV) : 36'd0);
        devREQI = 1'b1; devADDRI = mkAddr(0, 0, 1, 0, 1, 3'd3, 18'o0);
        step();
        idle();
        chk("wru_ack",  36'(devACKO), 36'(INTR));
        chk("wru_iack", 36'(intACK),  36'(INTR));
        intREQ = 1'b0;
        step(); step();

        // Randomized traffic.
        for (int i = 0; i < NRAND; i++) begin
            int unsigned kind, ar;
            logic [17:0] a;
            logic [2:0]  br;
            rst      = ($urandom_range(0, 199) == 0);
            devRESET = ($urandom_range(0, 149) == 0);
            devREQI  = ($urandom_range(0, 2) == 0);
            kind     = $urandom_range(0, 9);
            ar       = $urandom_range(0, 9);
            if (ar < 8)       a = 18'(BASE + $urandom_range(0, 2 * NREGS - 1));
            else if (ar == 8) a = 18'(BASE - $urandom_range(1, 2));
            else              a = 18'(BASE + 2 * NREGS + $urandom_range(0, 3));
            br = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            devADDRI = mkAddr(kind >= 4 && kind <= 7, kind <= 3 || kind == 7, kind == 8,
                              1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, br, a);
            devDATAI = {4'($urandom), 32'($urandom)};
            regRDY   = ($urandom_range(0, 3) == 0);
            rdv      = 18'($urandom);
            regRDATA = rdv;
            if ($urandom_range(0, 7) == 0) intREQ = ~intREQ;
            step();
        end
        idle();
        intREQ = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/uba_devif.md
# uba_devif

Generic device-side front end for the KS10 IO bus, sitting directly downstream of the Unibus Adapter on the `unibus.device` modport. It decodes UBA requests and turns them into single-cycle local register read/write strobes with a wait-state-capable read return. It generates the `devACKO`/`devDATAO` responses and, optionally, the interrupt request and WRU vector response. Every UBA-attached peripheral (DZ, LP, RH, KW) instantiates one copy in front of its register file.

## Interface
- UBANUM, 3'd3, IO bridge number this device answers to
- BASEADDR, 18'o760010, byte address of register 0 (must be even)
- NREGS, 8, number of 16-bit registers (power of two, 2..32)
- VECT, 18'o000300, interrupt vector returned on WRU
- INTLEV, 4'b0100, one-hot interrupt level driven onto devINTRO[7:4]
- clk  in  1  clock (single clock domain)
- rst  in  1  synchronous active-high reset
- devRESET  in  1  Unibus INIT; synchronous, same effect as rst
- devREQI, devADDRI[0:35], devDATAI[0:35]  in  request pulse, address/flags, write data
- devACKI  in  1  unused (DMA not supported)
- devACKO  out  1  acknowledge pulse
- devDATAO  out  36  read data / vector
- devINTRO  out  4  interrupt request, levels 7..4
- devREQO, devADDRO, devACLO  out  1/36/1  tied 0
- regADDR  out  $clog2(NREGS)  register index
- regWR, regRD  out  1  one-cycle strobes
- regBYTE, regHI  out  1  byte cycle; odd-byte lane
- regWDATA  out  18  devDATAI[18:35] registered
- regRDATA  in  18  local read data
- regRDY  in  1  read data valid (may assert in the same cycle as regRD)
- intREQ  in  1  device interrupt request (level)
- intACK  out  1  one-cycle pulse on vector read

## Operation
- Address flags: bit 3 read, bit 5 write, bit 6 WRU, bit 12 byte, bit 13 IO; bits 15:17 bridge; bits 18:35 address.
- Select: `devREQI & IO & bridge==UBANUM & BASEADDR <= addr < BASEADDR+2*NREGS`; `regADDR = (addr-BASEADDR)>>1`; `regHI = addr[35]`.
- FSM states: IDLE, WRITE, READ, RDWAIT, ACK.
- **IDLE:**
  - Selected write: latch address and data, go to WRITE.
  - Selected read: latch, go to READ.
  - WRU: handled only with interrupt support compiled in (see Configuration).
  - Unselected request: ignored, no ack; the UBA times out as NXM.
- **WRITE:** regWR=1 for one cycle; devACKO=1 in the same cycle; return to IDLE.
- **READ:** regRD=1 for one cycle.
  - If regRDY is also 1, capture regRDATA and go to ACK.
  - Otherwise go to RDWAIT.
- **RDWAIT:** wait for regRDY, then capture and go to ACK. There is no timeout.
- **ACK:** devACKO=1 for one cycle, then IDLE.
- devDATAO = {18'b0, captured data}. It holds until the next read or WRU capture.
- Read and write flags both set: treat as write.
- devREQI outside IDLE is ignored, with no ack and no strobes.
- rst or devRESET in any state: FSM to IDLE; all strobes, devACKO, devINTRO and intACK to 0; devDATAO to 0. Any in-progress transaction is dropped with no ack.

## Timing
- Request sampled in cycle N.
- Write: regWR and devACKO both in cycle N+1.
- Read with regRDY in N+1: devACKO in N+2, with devDATAO valid from N+2.
- Each cycle of regRDY delay adds one cycle.
- Minimum spacing between accepted requests: 2 cycles for a write, 3 cycles for a read.
- Reset values: every output 0.

## Configuration
- `UBA_DEVIF_INTR_EN` defined: interrupt support is compiled in.
  - devINTRO is registered: INTLEV when intREQ=1, else 0. It follows intREQ with 1 cycle delay.
  - WRU request in IDLE, with bridge match and devINTRO≠0: devDATAO={18'b0,VECT}, devACKO and intACK asserted in cycle N+1, back to IDLE.
  - WRU with devINTRO==0 or a bridge mismatch: ignored.
- `UBA_DEVIF_INTR_EN` undefined: interrupt support is compiled out.
  - devINTRO and intACK are constant 0.
  - WRU requests are ignored.
  - intREQ is unused.

## Structure
- Shared package `uba_pkg`:
  - Flag bit positions (FLAG_READ=3, FLAG_WRITE=5, FLAG_WRU=6, FLAG_BYTE=12, FLAG_IO=13).
  - Bridge field slice.
  - FSM state enum `devif_state_t`.
- One sub-module `uba_devif_dec`: combinational address/bridge/range decode producing `sel`, `wru` and the register index. The FSM lives in the top.

## Test plan
- Write 18'o123456 to UBANUM 3, address 760012: regADDR=1, regWR and devACKO both high in cycle N+1, regWDATA=18'o123456.
- Read address 760016 with regRDY tied 1 and regRDATA=18'o054321: regRD in N+1, devACKO in N+2, devDATAO=36'o000000054321.
- Read with regRDY delayed 5 cycles: devACKO exactly 1 cycle after regRDY. A second devREQI during the wait produces no strobe.
- Address 760010+2*NREGS, or bridge 1: no regRD/regWR, no devACKO ever.
- devRESET asserted in RDWAIT: FSM returns to IDLE, no ack. A subsequent write completes normally.
- With `UBA_DEVIF_INTR_EN`: intREQ=1 gives devINTRO=4'b0100 one cycle later. A WRU request then gives devDATAO=36'o000000000300 with devACKO and intACK in N+1. Without the macro, the same stimulus produces no ack.
